// File: rtl/mc_controller_ws_if.sv
// rtl/mc_controller_ws_if.sv - control bus between the multicycle controller and the datapath
interface mc_controller_ws_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       Err;
  logic       MemReady;
  logic       MemReq;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       RegWrite;
  logic       ExtOp;
  logic       LuiOp;
  logic       EPCWrite;
  logic       ErrTargetWrite;
  logic [1:0] MemtoReg;
  logic [1:0] RegDst;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] PCErrSource;
  logic [3:0] ALUOp;
  logic [1:0] ErrCause;
  logic [3:0] State;

  modport master (
    input  OpCode, Funct, Err, MemReady,
    output MemReq, PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
           RegWrite, ExtOp, LuiOp, EPCWrite, ErrTargetWrite, MemtoReg, RegDst,
           ALUSrcA, ALUSrcB, PCSource, PCErrSource, ALUOp, ErrCause, State
  );

  modport slave (
    output OpCode, Funct, Err, MemReady,
    input  MemReq, PCWrite, PCWriteCond, IorD, MemWrite, MemRead, IRWrite,
           RegWrite, ExtOp, LuiOp, EPCWrite, ErrTargetWrite, MemtoReg, RegDst,
           ALUSrcA, ALUSrcB, PCSource, PCErrSource, ALUOp, ErrCause, State
  );
endinterface

// File: rtl/mc_controller_ws.sv
// rtl/mc_controller_ws.sv - multicycle MIPS control FSM with handshaked variable-latency memory
module mc_controller_ws #(
  parameter int TIMEOUT_W = 4,
  parameter bit HAS_EXC   = 1'b1
) (
  input logic clk,
  input logic reset,
  mc_controller_ws_if.master bus
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_REX = 4'd2, S_RWB = 4'd3, S_MEMEX = 4'd4,
    S_SWMEM = 4'd5, S_LWMEM = 4'd6, S_LWWB = 4'd7, S_IEX = 4'd8, S_IWB = 4'd9,
    S_BEQ = 4'd10, S_JMP = 4'd11, S_ERR = 4'd12, S_ENDERR = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ENDERR = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08, FN_JALR = 6'h09;

  state_t               state, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [1:0]           err_cause;
  logic [1:0]           cause_next;
  logic                 mem_state;
  logic                 timeout;
  logic                 is_rtype;
  logic [2:0]           alu_lo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      wait_cnt  <= '0;
      err_cause <= 2'b00;
    end else begin
      state <= state_next;
      // Any transition (including into a memory state) restarts the wait count.
      if (state_next != state)
        wait_cnt <= '0;
      else if (!bus.MemReady)
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      if (state_next == S_ERR)
        err_cause <= cause_next;
    end
  end

  always_comb begin
    state_next         = state;
    cause_next         = 2'b00;
    is_rtype           = (bus.OpCode == OP_RTYPE);
    mem_state          = (state == S_IF) || (state == S_LWMEM) || (state == S_SWMEM);
    timeout            = HAS_EXC && mem_state && !bus.MemReady && (&wait_cnt);
    alu_lo             = 3'b000;
    bus.MemReq         = 1'b0;
    bus.PCWrite        = 1'b0;
    bus.PCWriteCond    = 1'b0;
    bus.IorD           = 1'b0;
    bus.MemWrite       = 1'b0;
    bus.MemRead        = 1'b0;
    bus.IRWrite        = 1'b0;
    bus.RegWrite       = 1'b0;
    bus.ExtOp          = 1'b0;
    bus.LuiOp          = 1'b0;
    bus.EPCWrite       = 1'b0;
    bus.ErrTargetWrite = 1'b0;
    bus.MemtoReg       = 2'b00;
    bus.RegDst         = 2'b00;
    bus.ALUSrcA        = 2'b00;
    bus.ALUSrcB        = 2'b00;
    bus.PCSource       = 2'b00;
    bus.PCErrSource    = 2'b00;

    case (state)
      S_IF: begin
        bus.MemReq  = 1'b1;
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = bus.MemReady;
        bus.IRWrite = bus.MemReady;
        if (bus.MemReady) state_next = S_ID;
        else if (timeout) begin state_next = S_ERR; cause_next = 2'b10; end
      end
      S_ID: begin
        bus.ALUSrcB = 2'b11;
        bus.ExtOp   = 1'b1;
        case (bus.OpCode)
          OP_ENDERR: state_next = S_ENDERR;
          OP_RTYPE:  state_next = (bus.Funct == FN_JR || bus.Funct == FN_JALR) ? S_JMP : S_REX;
          OP_LW, OP_SW: state_next = S_MEMEX;
          OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: state_next = S_IEX;
          OP_BEQ:    state_next = S_BEQ;
          OP_J, OP_JAL: state_next = S_JMP;
          default: begin
            state_next = HAS_EXC ? S_ERR : S_IF;
            cause_next = 2'b11;
          end
        endcase
      end
      S_REX: begin
        bus.ALUSrcA = (bus.Funct == FN_SLL || bus.Funct == FN_SRL || bus.Funct == FN_SRA) ? 2'b10 : 2'b01;
        if (HAS_EXC && bus.Err) begin state_next = S_ERR; cause_next = 2'b01; end
        else state_next = S_RWB;
      end
      S_MEMEX, S_IEX: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp   = (bus.OpCode != OP_ANDI);
        bus.LuiOp   = (bus.OpCode == OP_LUI);
        if (state == S_MEMEX) state_next = (bus.OpCode == OP_LW) ? S_LWMEM : S_SWMEM;
        else if (HAS_EXC && bus.Err) begin state_next = S_ERR; cause_next = 2'b01; end
        else state_next = S_IWB;
      end
      S_LWMEM, S_SWMEM: begin
        bus.MemReq   = 1'b1;
        bus.IorD     = 1'b1;
        bus.MemRead  = (state == S_LWMEM);
        bus.MemWrite = (state == S_SWMEM);
        if (bus.MemReady) state_next = (state == S_LWMEM) ? S_LWWB : S_IF;
        else if (timeout) begin state_next = S_ERR; cause_next = 2'b10; end
      end
      S_RWB: begin
        bus.RegWrite = 1'b1; bus.RegDst = 2'b01; bus.MemtoReg = 2'b01; state_next = S_IF;
      end
      S_IWB: begin
        bus.RegWrite = 1'b1; bus.MemtoReg = 2'b01; state_next = S_IF;
      end
      S_LWWB: begin
        bus.RegWrite = 1'b1; state_next = S_IF;
      end
      S_BEQ: begin
        bus.ALUSrcA = 2'b01; bus.PCWriteCond = 1'b1; bus.PCSource = 2'b01; state_next = S_IF;
      end
      S_JMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = is_rtype ? 2'b11 : 2'b10;
        // jal and jalr link the return address.
        if (bus.OpCode == OP_JAL || (is_rtype && bus.Funct == FN_JALR)) begin
          bus.RegWrite = 1'b1; bus.RegDst = 2'b10; bus.MemtoReg = 2'b10;
        end
        state_next = S_IF;
      end
      S_ERR: begin
        bus.PCWrite = 1'b1; bus.PCErrSource = 2'b01; bus.EPCWrite = 1'b1;
        bus.ErrTargetWrite = 1'b1; state_next = S_IF;
      end
      S_ENDERR: begin
        bus.PCWrite = 1'b1; bus.PCErrSource = 2'b10; bus.RegWrite = 1'b1;
        bus.RegDst = 2'b11; bus.MemtoReg = 2'b11; state_next = S_IF;
      end
      default: state_next = S_IF;
    endcase

    if (state != S_IF && state != S_ID) begin
      if (is_rtype) alu_lo = 3'b010;
      else if (bus.OpCode == OP_BEQ) alu_lo = 3'b001;
      else if (bus.OpCode == OP_ANDI) alu_lo = 3'b100;
      else if (bus.OpCode == OP_SLTI || bus.OpCode == OP_SLTIU) alu_lo = 3'b101;
    end
    bus.ALUOp = {bus.OpCode[0], alu_lo};

    if (reset) begin
      bus.MemReq = 1'b0; bus.PCWrite = 1'b0; bus.PCWriteCond = 1'b0; bus.IorD = 1'b0;
      bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.IRWrite = 1'b0; bus.RegWrite = 1'b0;
      bus.ExtOp = 1'b0; bus.LuiOp = 1'b0; bus.EPCWrite = 1'b0; bus.ErrTargetWrite = 1'b0;
      bus.MemtoReg = 2'b00; bus.RegDst = 2'b00; bus.ALUSrcA = 2'b00; bus.ALUSrcB = 2'b00;
      bus.PCSource = 2'b00; bus.PCErrSource = 2'b00; bus.ALUOp = 4'b0000;
    end
  end

  assign bus.ErrCause = err_cause;
  assign bus.State    = state;

endmodule

// File: tb/tb_mc_controller_ws.sv
// tb/tb_mc_controller_ws.sv - directed-vector bench for mc_controller_ws
module tb_mc_controller_ws;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, fn;
  logic       err, rdy;
  int         total = 0;
  int         bad = 0;

  mc_controller_ws_if bus0();
  mc_controller_ws_if bus1();

  assign bus0.OpCode = op;  assign bus0.Funct = fn;  assign bus0.Err = err;  assign bus0.MemReady = rdy;
  assign bus1.OpCode = op;  assign bus1.Funct = fn;  assign bus1.Err = err;  assign bus1.MemReady = rdy;

  mc_controller_ws #(.TIMEOUT_W(2), .HAS_EXC(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mc_controller_ws #(.TIMEOUT_W(4), .HAS_EXC(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 6'h00; fn = 6'h00; err = 1'b0; rdy = 1'b1;
    tick(); tick();
    op = 6'h23; #1;
    chk("rst_state", int'(bus0.State), 0);
    chk("rst_memreq", int'(bus0.MemReq), 0);
    chk("rst_aluop", int'(bus0.ALUOp), 0);
    chk("rst_cause", int'(bus0.ErrCause), 0);

    // add: IF, ID, REX, RWB, IF
    reset = 1'b0; op = 6'h00; fn = 6'h20; #1;
    chk("if_state", int'(bus0.State), 0);
    chk("if_pcw", int'(bus0.PCWrite), 1);
    chk("if_irw", int'(bus0.IRWrite), 1);
    chk("if_srcb", int'(bus0.ALUSrcB), 1);
    tick();
    chk("id_state", int'(bus0.State), 1);
    chk("id_srcb", int'(bus0.ALUSrcB), 3);
    chk("id_aluop", int'(bus0.ALUOp), 0);
    tick();
    chk("rex_state", int'(bus0.State), 2);
    chk("rex_srca", int'(bus0.ALUSrcA), 1);
    chk("rex_aluop", int'(bus0.ALUOp), 2);
    tick();
    chk("rwb_state", int'(bus0.State), 3);
    chk("rwb_regw", int'(bus0.RegWrite), 1);
    chk("rwb_regdst", int'(bus0.RegDst), 1);
    tick();
    chk("add_done", int'(bus0.State), 0);

    // lw with three not-ready cycles in LWMEM; ready lands when counter is all-ones
    op = 6'h23; tick(); tick();
    chk("memex_state", int'(bus0.State), 4);
    chk("memex_aluop", int'(bus0.ALUOp), 8);
    chk("memex_srcb", int'(bus0.ALUSrcB), 2);
    rdy = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      chk("lwmem_state", int'(bus0.State), 6);
      chk("lwmem_req", int'(bus0.MemReq), 1);
      chk("lwmem_iord", int'(bus0.IorD), 1);
      tick();
    end
    rdy = 1'b1; #1;
    chk("lwmem_last", int'(bus0.State), 6);
    chk("lwmem_rd", int'(bus0.MemRead), 1);
    tick();
    chk("lwwb_state", int'(bus0.State), 7);
    chk("lwwb_regw", int'(bus0.RegWrite), 1);
    chk("lwwb_m2r", int'(bus0.MemtoReg), 0);
    tick();
    chk("lw_done", int'(bus0.State), 0);

    // IF bus timeout with TIMEOUT_W=2
    rdy = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_if_state", int'(bus0.State), 0);
      chk("to_if_pcw", int'(bus0.PCWrite), 0);
      chk("to_if_irw", int'(bus0.IRWrite), 0);
      tick();
    end
    chk("to_err_state", int'(bus0.State), 12);
    chk("to_cause", int'(bus0.ErrCause), 2);
    chk("to_epcw", int'(bus0.EPCWrite), 1);
    chk("to_pcerr", int'(bus0.PCErrSource), 1);
    rdy = 1'b1; tick();
    chk("to_back_if", int'(bus0.State), 0);

    // ENDERR keeps the cause
    op = 6'h01; tick(); tick();
    chk("enderr_state", int'(bus0.State), 13);
    chk("enderr_regdst", int'(bus0.RegDst), 3);
    chk("enderr_pcerr", int'(bus0.PCErrSource), 2);
    chk("enderr_cause", int'(bus0.ErrCause), 2);
    tick();

    // addi overflow
    op = 6'h08; err = 1'b1; tick(); tick();
    chk("iex_state", int'(bus0.State), 8);
    chk("iex_regw", int'(bus0.RegWrite), 0);
    tick();
    chk("ovf_state", int'(bus0.State), 12);
    chk("ovf_cause", int'(bus0.ErrCause), 1);
    chk("ovf_epcw", int'(bus0.EPCWrite), 1);
    chk("ovf_regw", int'(bus0.RegWrite), 0);
    err = 1'b0; tick();

    // reset during LWMEM
    op = 6'h23; tick(); tick(); rdy = 1'b0; tick();
    chk("rl_lwmem", int'(bus0.State), 6);
    reset = 1'b1; #1;
    chk("rl_req", int'(bus0.MemReq), 0);
    chk("rl_iord", int'(bus0.IorD), 0);
    chk("rl_rd", int'(bus0.MemRead), 0);
    tick();
    chk("rl_state", int'(bus0.State), 0);
    chk("rl_cause", int'(bus0.ErrCause), 0);
    chk("rl_state1", int'(bus1.State), 0);
    reset = 1'b0; rdy = 1'b1;

    // jalr
    op = 6'h00; fn = 6'h09; tick(); tick();
    chk("jalr_state", int'(bus0.State), 11);
    chk("jalr_pcsrc", int'(bus0.PCSource), 3);
    chk("jalr_regdst", int'(bus0.RegDst), 2);
    chk("jalr_regw", int'(bus0.RegWrite), 1);
    tick();

    // andi
    op = 6'h0c; tick(); tick();
    chk("andi_ext", int'(bus0.ExtOp), 0);
    chk("andi_aluop", int'(bus0.ALUOp), 4);
    tick();
    chk("iwb_state", int'(bus0.State), 9);
    chk("iwb_m2r", int'(bus0.MemtoReg), 1);
    tick();

    // beq
    op = 6'h04; tick(); tick();
    chk("beq_state", int'(bus0.State), 10);
    chk("beq_cond", int'(bus0.PCWriteCond), 1);
    chk("beq_aluop", int'(bus0.ALUOp), 1);
    tick();

    // sw
    op = 6'h2b; tick(); tick(); tick();
    chk("sw_state", int'(bus0.State), 5);
    chk("sw_memw", int'(bus0.MemWrite), 1);
    tick();
    chk("sw_done", int'(bus0.State), 0);

    // illegal opcode, with and without exceptions
    op = 6'h3f; tick();
    chk("ill_id0", int'(bus0.State), 1);
    chk("ill_id1", int'(bus1.State), 1);
    tick();
    chk("ill_err0", int'(bus0.State), 12);
    chk("ill_cause0", int'(bus0.ErrCause), 3);
    chk("ill_nop1", int'(bus1.State), 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
